// File: rtl/exporter_arbiter.sv
// exporter_arbiter: round-robin sharing of one data_exporter display engine.
// Latches the winning requester's word, holds exp_en high for a fixed frame,
// then forces a low gap so the exporter restarts cleanly between frames.
module exporter_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 28,
    parameter int FRAME_CYCLES = 45,
    parameter int GAP_CYCLES   = 4,
    parameter int REPEAT       = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          ack,
    output logic                        exp_en,
    output logic [DATA_W-1:0]           exp_data,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy
);

    localparam int IW   = $clog2(NUM_REQ);
    localparam int MAXC = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       last_q, last_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [IW-1:0]       gid_q, gid_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                en_q, en_d;
    logic                busy_q, busy_d;

    logic                found;
    logic [IW-1:0]       win;
    logic [IW-1:0]       cand;

    // Next-state logic: round-robin search, frame/gap counting, output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        valid_d = valid_q;
        data_d  = data_q;
        gid_d   = gid_q;
        ack_d   = '0;
        found   = 1'b0;
        win     = last_q;
        cand    = '0;

        // Priority starts just after the last winner and wraps around.
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = IW'((32'(last_q) + off) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    data_d     = req_data[win*DATA_W +: DATA_W];
                    gid_d      = win;
                    last_d     = win;
                    ack_d[win] = 1'b1;
                    valid_d    = 1'b1;
                    state_d    = SHOW;
                    cnt_d      = '0;
                end else if (REPEAT != 0 && valid_q) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end
            end
            SHOW: begin
                if (cnt_q == FRAME_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        en_d   = (state_d == SHOW);
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            valid_q <= 1'b0;
            data_q  <= '0;
            gid_q   <= '0;
            ack_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            gid_q   <= gid_d;
            ack_q   <= ack_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
        end
    end

    assign ack      = ack_q;
    assign exp_en   = en_q;
    assign exp_data = data_q;
    assign grant_id = gid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_exporter_arbiter.sv
// tb_exporter_arbiter: two arbiters (REPEAT=0 and REPEAT=1) against a
// frame-position reference model, plus directed literal checks.
module tb_exporter_arbiter;

    localparam int FR = 10;
    localparam int GP = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req_a, req_b;
    logic [111:0]  data_a, data_b;
    logic [3:0]    ack_a, ack_b;
    logic          exp_en_a, exp_en_b;
    logic [27:0]   exp_data_a, exp_data_b;
    logic [1:0]    gid_a, gid_b;
    logic          busy_a, busy_b;

    int vectors = 0;
    int miscompares = 0;
    int cyc_n = 0;
    bit auto_on = 0;

    // Model state per instance: m_t = position in frame (0 idle, 1..FR show, FR+1..FR+GP gap)
    int         m_t[2]     = '{0, 0};
    int         m_last[2]  = '{3, 3};
    bit         m_valid[2] = '{0, 0};
    logic [27:0] m_data[2] = '{28'h0, 28'h0};
    int         m_gid[2]   = '{0, 0};
    logic [3:0] m_ack[2]   = '{4'h0, 4'h0};

    always #5 clk = ~clk;

    exporter_arbiter #(.NUM_REQ(4), .DATA_W(28), .FRAME_CYCLES(FR), .GAP_CYCLES(GP), .REPEAT(0)) u_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .req_data(data_a), .ack(ack_a),
        .exp_en(exp_en_a), .exp_data(exp_data_a), .grant_id(gid_a), .busy(busy_a));

    exporter_arbiter #(.NUM_REQ(4), .DATA_W(28), .FRAME_CYCLES(FR), .GAP_CYCLES(GP), .REPEAT(1)) u_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .req_data(data_b), .ack(ack_b),
        .exp_en(exp_en_b), .exp_data(exp_data_b), .grant_id(gid_b), .busy(busy_b));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc_n, act, exp);
        end
    endtask

    task automatic step(input int r, input logic [3:0] rq, input logic [111:0] dt, input bit rep);
        int c;
        bit found;
        m_ack[r] = 4'h0;
        if (!rst_n) begin
            m_t[r] = 0; m_last[r] = 3; m_valid[r] = 0; m_data[r] = 28'h0; m_gid[r] = 0;
        end else if (m_t[r] == 0) begin
            found = 0;
            for (int k = 1; k <= 4; k++) begin
                c = (m_last[r] + k) % 4;
                if (!found && rq[c]) begin
                    found = 1;
                    m_data[r] = dt[c*28 +: 28];
                    m_gid[r] = c;
                    m_last[r] = c;
                    m_ack[r] = 4'(1 << c);
                end
            end
            if (found) begin
                m_valid[r] = 1;
                m_t[r] = 1;
            end else if (rep && m_valid[r]) begin
                m_t[r] = 1;
            end
        end else if (m_t[r] == FR + GP) begin
            m_t[r] = 0;
        end else begin
            m_t[r]++;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            step(0, req_a, data_a, 0);
            step(1, req_b, data_b, 1);
        end
    end

    task automatic cmp(input int r, input logic [3:0] ak, input logic en, input logic [27:0] d,
                       input logic [1:0] g, input logic b);
        logic [3:0] eak; logic een; logic [27:0] ed; int eg; logic eb;
        if (!rst_n) begin
            eak = 4'h0; een = 0; ed = 28'h0; eg = 0; eb = 0;
        end else begin
            eak = m_ack[r];
            een = (m_t[r] >= 1 && m_t[r] <= FR);
            ed  = m_data[r];
            eg  = m_gid[r];
            eb  = (m_t[r] != 0);
        end
        chk(r == 0 ? "A.ack" : "B.ack", 32'(ak), 32'(eak));
        chk(r == 0 ? "A.exp_en" : "B.exp_en", 32'(en), 32'(een));
        chk(r == 0 ? "A.exp_data" : "B.exp_data", 32'(d), 32'(ed));
        chk(r == 0 ? "A.grant_id" : "B.grant_id", 32'(g), eg);
        chk(r == 0 ? "A.busy" : "B.busy", 32'(b), 32'(eb));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cmp(0, ack_a, exp_en_a, exp_data_a, gid_a, busy_a);
            cmp(1, ack_b, exp_en_b, exp_data_b, gid_b, busy_b);
        end
    end

    task automatic auto_upd(input logic [3:0] ak, inout logic [3:0] rq, inout logic [111:0] dt);
        int j;
        for (int i = 0; i < 4; i++) begin
            if (ak[i]) rq[i] = 1'b0;
            else if (!rq[i] && $urandom_range(0, 5) == 0) begin
                rq[i] = 1'b1;
                dt[i*28 +: 28] = 28'($urandom);
            end
        end
        if ($urandom_range(0, 7) == 0) begin
            j = $urandom_range(0, 3);
            dt[j*28 +: 28] = 28'($urandom);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
        cyc_n++;
        if (auto_on) begin
            auto_upd(ack_a, req_a, data_a);
            auto_upd(ack_b, req_b, data_b);
        end
    endtask

    task automatic wait_idle_a();
        int n = 0;
        while (busy_a && n < 40) begin
            cyc();
            n++;
        end
        if (busy_a) chk("A.idle_timeout", 32'(busy_a), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gl[5];
        int gc[5];
        int ng;
        int exp_rr[5] = '{0, 1, 2, 3, 0};
        logic [3:0] pend;
        int g2[2];
        int n2;
        int rise[3];
        int nr;
        logic prev;
        int ackc;

        rst_n = 1'b0; req_a = '0; req_b = '0; data_a = '0; data_b = '0;
        cyc(); cyc();
        chk("rst.ack", 32'(ack_a), 0);
        chk("rst.exp_en", 32'(exp_en_a), 0);
        chk("rst.exp_data", 32'(exp_data_a), 0);
        chk("rst.grant_id", 32'(gid_a), 0);
        chk("rst.busy", 32'(busy_a), 0);
        rst_n = 1'b1;
        cyc();

        // Round robin with all four requesters, drop on ack, re-raise next cycle
        data_a = {28'h00000D3, 28'h00000C2, 28'h00000B1, 28'h00000A0};
        req_a = 4'hF; pend = '0; ng = 0;
        for (int n = 0; n < 90 && ng < 5; n++) begin
            cyc();
            for (int i = 0; i < 4; i++) if (pend[i]) begin req_a[i] = 1'b1; pend[i] = 1'b0; end
            if (ack_a != 0) begin
                chk("rr.onehot", $countones(ack_a), 1);
                for (int i = 0; i < 4; i++) if (ack_a[i] && ng < 5) begin
                    gl[ng] = i; gc[ng] = cyc_n; req_a[i] = 1'b0; pend[i] = 1'b1;
                end
                ng++;
            end
        end
        req_a = '0;
        chk("rr.count", ng, 5);
        for (int j = 0; j < 5 && j < ng; j++) begin
            chk("rr.order", gl[j], exp_rr[j]);
            if (j > 0) chk("rr.period", gc[j] - gc[j-1], 13);
        end
        wait_idle_a();

        // Single request on requester 1, with its data changed mid-frame
        data_a[28 +: 28] = 28'h821ED34;
        req_a[1] = 1'b1;
        cyc();
        req_a[1] = 1'b0;
        chk("single.ack", 32'(ack_a), 32'h2);
        chk("single.exp_en", 32'(exp_en_a), 1);
        chk("single.grant_id", 32'(gid_a), 1);
        chk("single.exp_data", 32'(exp_data_a), 32'h821ED34);
        chk("single.busy", 32'(busy_a), 1);
        chk("pin.model_data", 32'(m_data[0]), 32'h821ED34);
        chk("pin.model_gid", m_gid[0], 1);
        for (int n = 1; n <= 9; n++) begin
            cyc();
            if (n == 3) data_a[28 +: 28] = 28'hABCDEF1;
            chk("single.frame_en", 32'(exp_en_a), 1);
            chk("single.hold_data", 32'(exp_data_a), 32'h821ED34);
            chk("single.ack_once", 32'(ack_a), 0);
        end
        cyc(); chk("single.gap1_en", 32'(exp_en_a), 0); chk("single.gap1_busy", 32'(busy_a), 1);
        cyc(); chk("single.gap2_en", 32'(exp_en_a), 0); chk("single.gap2_busy", 32'(busy_a), 1);
        cyc(); chk("single.idle_en", 32'(exp_en_a), 0); chk("single.idle_busy", 32'(busy_a), 0);

        // After a grant to 1, requesters 0 and 2 together: 2 wins first
        req_a = 4'b0010;
        cyc();
        chk("rr2.first_ack", 32'(ack_a), 32'h2);
        req_a = '0;
        cyc(); cyc();
        req_a = 4'b0101;
        n2 = 0;
        for (int n = 0; n < 40 && n2 < 2; n++) begin
            cyc();
            if (ack_a != 0) begin
                for (int i = 0; i < 4; i++) if (ack_a[i]) begin g2[n2] = i; req_a[i] = 1'b0; end
                n2++;
            end
        end
        chk("rr2.count", n2, 2);
        if (n2 == 2) begin
            chk("rr2.first", g2[0], 2);
            chk("rr2.second", g2[1], 0);
        end
        req_a = '0;
        wait_idle_a();

        // Reset in SHOW cycle 5 with requester 2 held
        req_a = 4'b0100;
        data_a[56 +: 28] = 28'h5A5A5A5;
        cyc();
        chk("rstmid.ack", 32'(ack_a), 32'h4);
        repeat (4) cyc();
        chk("rstmid.pre_en", 32'(exp_en_a), 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid.en", 32'(exp_en_a), 0);
        chk("rstmid.busy", 32'(busy_a), 0);
        chk("rstmid.ack0", 32'(ack_a), 0);
        chk("rstmid.data", 32'(exp_data_a), 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("rstmid.regrant_ack", 32'(ack_a), 32'h4);
        chk("rstmid.regrant_gid", 32'(gid_a), 2);
        chk("rstmid.regrant_en", 32'(exp_en_a), 1);
        req_a = '0;
        wait_idle_a();

        // REPEAT=1 instance: single request on 3, then redisplay with no ack
        data_b[84 +: 28] = 28'h0000034;
        req_b = 4'b1000;
        cyc();
        req_b = '0;
        chk("rep.ack", 32'(ack_b), 32'h8);
        chk("rep.gid", 32'(gid_b), 3);
        chk("rep.data", 32'(exp_data_b), 32'h34);
        rise[0] = cyc_n; nr = 1; prev = exp_en_b;
        for (int n = 0; n < 60 && nr < 3; n++) begin
            cyc();
            chk("rep.noack", 32'(ack_b), 0);
            if (exp_en_b && !prev) begin
                rise[nr] = cyc_n;
                chk("rep.rise_gid", 32'(gid_b), 3);
                chk("rep.rise_data", 32'(exp_data_b), 32'h34);
                nr++;
            end
            prev = exp_en_b;
        end
        chk("rep.rises", nr, 3);
        if (nr == 3) begin
            chk("rep.period1", rise[1] - rise[0], 13);
            chk("rep.period2", rise[2] - rise[1], 13);
        end
        repeat (4) cyc();
        data_b[0 +: 28] = 28'h1234567;
        req_b[0] = 1'b1;
        ackc = -1;
        for (int n = 0; n < 30 && ackc < 0; n++) begin
            cyc();
            if (ack_b != 0) ackc = cyc_n;
        end
        req_b = '0;
        chk("rep.mid_ack", 32'(ack_b), 32'h1);
        chk("rep.mid_latency", ackc - rise[2], 13);

        // Randomized traffic on both instances
        auto_on = 1;
        repeat (800) cyc();
        auto_on = 0;
        req_a = '0; req_b = '0;
        repeat (20) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
